// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the mode-0 SPI master sequencer.
//   spi_state_e  : sequencer states (IDLE, SETUP, HIGH, LOW, HOLD)
//   SPI_SIZE_DEF : default bits per frame
//   SPI_DIV_DEF  : default Clk cycles per SClk half-period
//   cnt_width()  : counter width helper, max(1, $clog2(n))
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } spi_state_e;

  localparam int SPI_SIZE_DEF = 8;
  localparam int SPI_DIV_DEF  = 2;

  // A counter that only ever needs to hold zero still needs one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/spi_tick_cnt.sv
// -----------------------------------------------------------------------------
// spi_tick_cnt
// Half-period down-counter for the SPI sequencer. Load reloads DIV-1; the
// counter then counts down to zero and holds. Expire is high while the count
// is zero, i.e. during the last Clk cycle of a half-period.
// Ports:
//   Clk    : system clock
//   Rst    : asynchronous active-high reset (count returns to 0)
//   Load   : reload the half-period count (asserted on every state change)
//   Expire : current cycle is the last one of the half-period
// -----------------------------------------------------------------------------
module spi_tick_cnt
  import spi_pkg::*;
#(
  parameter int DIV = SPI_DIV_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Load,
  output logic Expire
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= '0;
    end else if (Load) begin
      cnt_q <= RELOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign Expire = (cnt_q == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// Mode-0 (CPOL=0, CPHA=0) SPI master sequencer. Produces SClk, SS_n and the
// one-cycle strobes that drive external TX/RX shift registers; carries no data.
//
// Host handshake: Start is sampled only while the sequencer is idle (Busy=0,
// which includes the Done cycle); a Start seen while Busy=1 is dropped, not
// queued. Busy stays high from the first SETUP cycle through the last HOLD
// cycle. Done pulses for one cycle when the frame completes and the RX shift
// register holds the full received word in that cycle.
//
// Build option: define SPI_BURST_EN to let a Start seen in the last HOLD cycle
// chain straight into the next frame without releasing SS_n.
//
// Ports:
//   Clk      : system clock, posedge
//   Rst      : asynchronous active-high reset
//   Start    : frame request
//   Busy     : frame in progress
//   Done     : frame complete pulse
//   SClk     : SPI clock, idle low
//   SS_n     : slave select, active low
//   TxLoad   : parallel-load TX shift register (first SETUP cycle)
//   TxShift  : advance TX shift register (first LOW cycle)
//   RxEn     : RX shift register capture (first HIGH cycle)
//   DbgState : current sequencer state (spi_state_e encoding)
// -----------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int SIZE = SPI_SIZE_DEF,
  parameter int DIV  = SPI_DIV_DEF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic       SClk,
  output logic       SS_n,
  output logic       TxLoad,
  output logic       TxShift,
  output logic       RxEn,
  output logic [2:0] DbgState
);

  localparam int BW = cnt_width(SIZE);
  localparam logic [BW-1:0] LAST_BIT = BW'(SIZE - 1);

  spi_state_e    state_q, state_d;
  logic [BW-1:0] bit_q;
  logic          tick_load, tick_expire;

  logic busy_d, done_d, sclk_d, ss_n_d, txload_d, txshift_d, rxen_d;

  // Every state change starts a fresh half-period.
  assign tick_load = (state_d != state_q);

  spi_tick_cnt #(
    .DIV (DIV)
  ) u_tick (
    .Clk    (Clk),
    .Rst    (Rst),
    .Load   (tick_load),
    .Expire (tick_expire)
  );

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) state_d = SETUP;
      end
      SETUP: begin
        if (tick_expire) state_d = HIGH;
      end
      HIGH: begin
        if (tick_expire) state_d = (bit_q == LAST_BIT) ? HOLD : LOW;
      end
      LOW: begin
        if (tick_expire) state_d = HIGH;
      end
      HOLD: begin
        if (tick_expire) begin
`ifdef SPI_BURST_EN
          state_d = Start ? SETUP : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit index: cleared whenever a frame is (re)started, bumped on each LOW entry.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      bit_q <= '0;
    end else if (state_q == IDLE || state_d == SETUP) begin
      bit_q <= '0;
    end else if (state_d == LOW && state_q != LOW) begin
      bit_q <= bit_q + BW'(1);
    end
  end

  // Output logic: decoded from the state being entered so the registered
  // outputs line up with the state they describe.
  always_comb begin
    busy_d    = (state_d != IDLE);
    ss_n_d    = (state_d == IDLE);
    sclk_d    = (state_d == HIGH);
    txload_d  = (state_d == SETUP) && (state_q != SETUP);
    rxen_d    = (state_d == HIGH)  && (state_q != HIGH);
    txshift_d = (state_d == LOW)   && (state_q != LOW);
    done_d    = (state_q == HOLD)  && (state_d != HOLD);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      SClk    <= 1'b0;
      SS_n    <= 1'b1;
      TxLoad  <= 1'b0;
      TxShift <= 1'b0;
      RxEn    <= 1'b0;
    end else begin
      Busy    <= busy_d;
      Done    <= done_d;
      SClk    <= sclk_d;
      SS_n    <= ss_n_d;
      TxLoad  <= txload_d;
      TxShift <= txshift_d;
      RxEn    <= rxen_d;
    end
  end

  assign DbgState = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl: one instance at SIZE=8/DIV=2 with a
// behavioural mode-0 slave (returns 0xA5) and RX shift register, plus one
// instance at SIZE=4/DIV=1. Honours SPI_BURST_EN for the back-to-back case.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic busy, done, sclk, ss_n, txload, txshift, rxen;
  logic [2:0] dbg;
  logic busy_2, done_2, sclk_2, ss_n_2, txload_2, txshift_2, rxen_2;
  logic [2:0] dbg_2;

  spi_master_ctrl #(.SIZE(8), .DIV(2)) u_dut (
    .Clk(clk), .Rst(rst), .Start(start), .Busy(busy), .Done(done),
    .SClk(sclk), .SS_n(ss_n), .TxLoad(txload), .TxShift(txshift),
    .RxEn(rxen), .DbgState(dbg)
  );

  spi_master_ctrl #(.SIZE(4), .DIV(1)) u_dut2 (
    .Clk(clk), .Rst(rst), .Start(start2), .Busy(busy_2), .Done(done_2),
    .SClk(sclk_2), .SS_n(ss_n_2), .TxLoad(txload_2), .TxShift(txshift_2),
    .RxEn(rxen_2), .DbgState(dbg_2)
  );

  // ---------------- scoreboard / monitor state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] slave_data = 8'hA5;
  logic [7:0] slave_sr   = 8'h00;
  logic [7:0] rx_model   = 8'h00;
  logic [7:0] rx_at_done = 8'h00;
  logic prev_sclk = 1'b0;
  logic prev_ss_n = 1'b1;
  int cyc = 0;
  int start_cyc = 0;
  int first_done_idx = -1;
  int last_done_cyc = 0;
  int done_spacing = 0;
  int n_txload, n_txshift, n_rxen, n_rise, n_done;
  int ss_hi_run, n_gaps, max_gap, min_gap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_txload = 0; n_txshift = 0; n_rxen = 0; n_rise = 0; n_done = 0;
    ss_hi_run = 0; n_gaps = 0; max_gap = 0; min_gap = 1000;
    first_done_idx = -1; done_spacing = 0; rx_model = 8'h00;
    prev_sclk = sclk; prev_ss_n = ss_n;
  endtask

  // One clock; sample #1 after the edge and update the slave / RX models.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_sclk && !sclk) slave_sr = {slave_sr[6:0], 1'b0};
    if (!prev_sclk && sclk) n_rise++;
    if (txload) begin
      if (n_txload == 0) start_cyc = cyc;
      n_txload++;
      slave_sr = slave_data;
    end
    if (rxen) begin
      rx_model = {rx_model[6:0], slave_sr[7]};
      n_rxen++;
    end
    if (txshift) n_txshift++;
    if (done) begin
      if (n_done == 0) first_done_idx = cyc - start_cyc;
      else             done_spacing   = cyc - last_done_cyc;
      last_done_cyc = cyc;
      n_done++;
      rx_at_done = rx_model;
    end
    if (ss_n) begin
      ss_hi_run++;
    end else begin
      if (prev_ss_n && n_done > 0) begin
        n_gaps++;
        if (ss_hi_run > max_gap) max_gap = ss_hi_run;
        if (ss_hi_run < min_gap) min_gap = ss_hi_run;
      end
      ss_hi_run = 0;
    end
    prev_sclk = sclk;
    prev_ss_n = ss_n;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int k;
    int target;
    k = 0;
    target = n_done + 1;
    while (n_done < target && k < bound) begin
      tick();
      k++;
    end
    check(tag, 32'(n_done >= target), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int r2, s2;
    clear_counts();

    // Reset and idle
    repeat (3) tick();
    check("rst_ss_n", ss_n, 1);
    check("rst_busy", busy, 0);
    check("rst_state", dbg, 32'(IDLE));
    rst = 1'b0;
    clear_counts();
    repeat (10) tick();
    check("idle_ss_n", ss_n, 1);
    check("idle_sclk", sclk, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_strobes", {txload, txshift, rxen}, 0);
    check("idle_activity", n_txload + n_txshift + n_rxen + n_rise + n_done, 0);
    check("idle_state", dbg, 32'(IDLE));
    check("idle2_ss_n", ss_n_2, 1);

    // Single frame
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f1_txload", txload, 1);
    check("f1_busy", busy, 1);
    check("f1_ss_n", ss_n, 0);
    check("f1_state", dbg, 32'(SETUP));
    wait_done(60, "f1_done_seen");
    check("f1_done_idx", first_done_idx, 34);
    check("f1_done_busy", busy, 0);
    check("f1_done_ss_n", ss_n, 1);
    check("f1_rxen", n_rxen, 8);
    check("f1_txshift", n_txshift, 7);
    check("f1_txload_cnt", n_txload, 1);
    check("f1_sclk_rises", n_rise, 8);
    check("f1_rx_data", rx_at_done, 8'hA5);
    tick();
    check("f1_done_pulse", done, 0);

    // Start pulsed mid-frame is ignored
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60, "f2_done_seen");
    check("f2_done_idx", first_done_idx, 34);
    repeat (40) tick();
    check("f2_done_cnt", n_done, 1);
    check("f2_txload_cnt", n_txload, 1);
    check("f2_idle_busy", busy, 0);

    // Start held high: back-to-back frames
    clear_counts();
    start = 1'b1;
    begin
      int k;
      k = 0;
      while (n_done < 3 && k < 200) begin
        tick();
        k++;
      end
    end
    check("b2b_three_done", n_done, 3);
    start = 1'b0;
`ifdef SPI_BURST_EN
    check("b2b_burst_txload", txload, 1);
    check("b2b_burst_busy", busy, 1);
    wait_done(60, "b2b_last_done");
    repeat (5) tick();
    check("b2b_done_cnt", n_done, 4);
    check("b2b_gaps", n_gaps, 0);
    check("b2b_spacing", done_spacing, 34);
`else
    repeat (40) tick();
    check("b2b_done_cnt", n_done, 3);
    check("b2b_gaps", n_gaps, 2);
    check("b2b_gap_max", max_gap, 1);
    check("b2b_gap_min", min_gap, 1);
    check("b2b_spacing", done_spacing, 35);
`endif
    check("b2b_idle_busy", busy, 0);

    // Reset mid-frame
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check("mr_pre_sclk", sclk, 1);
    check("mr_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_ss_n", ss_n, 1);
    check("mr_sclk", sclk, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_strobes", {txload, txshift, rxen}, 0);
    check("mr_state", dbg, 32'(IDLE));
    tick();
    tick();
    rst = 1'b0;
    repeat (40) tick();
    check("mr_no_done", n_done, 0);
    clear_counts();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60, "mr_f_done_seen");
    check("mr_f_done_idx", first_done_idx, 34);
    check("mr_f_rxen", n_rxen, 8);
    check("mr_f_rx_data", rx_at_done, 8'hA5);

    // SIZE=4, DIV=1 instance
    r2 = 0;
    s2 = 0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("d2_txload", txload_2, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) tick();
      check("d2_sclk", sclk_2, 32'(i % 2));
      check("d2_no_done", done_2, 0);
      if (rxen_2) r2++;
      if (txshift_2) s2++;
    end
    tick();
    check("d2_done_at_9", done_2, 1);
    check("d2_rxen", r2, 4);
    check("d2_txshift", s2, 3);
    check("d2_busy", busy_2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
